// File: rtl/positron_sched_pkg.sv
// Shared types and helpers for the positron frame scheduler.
package positron_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAD  = 2'd2
  } sched_state_e;

  function automatic int wc_width(input int nb_upstream);
    return $clog2(nb_upstream);
  endfunction

  // Posit zero is the all-zero bit pattern; callers replicate this bit.
  function automatic logic posit_zero_bit();
    return 1'b0;
  endfunction

endpackage

// File: rtl/positron_sched_checker.sv
// Protocol checker for the frame scheduler, compiled only with ASSERT_EN.
`ifdef ASSERT_EN
module positron_sched_checker (
  input logic clk,
  input logic rst_n,
  input logic out_xfer,
  input logic credits_zero
);

  // An output word with no frame in flight means layer and scheduler disagree.
  a_no_orphan_output: assert property (@(posedge clk) disable iff (!rst_n)
    !(out_xfer && credits_zero));

endmodule
`endif

// File: rtl/sched_flag_fifo.sv
// Small 1-bit FIFO holding the DMA tlast flag of every admitted frame.
module sched_flag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = mem_r[rd_ptr_r] & ~empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r    <= {DEPTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/positron_frame_scheduler.sv
// Frame cutter / credit limiter in front of a positron layer.
// Optional statistics counters are enabled with POSITRON_SCHED_STATS_EN.
module positron_frame_scheduler
  import positron_sched_pkg::*;
#(
  parameter int NB_UPSTREAM_POSITRON = 784,
  parameter int NB_POSITRON          = 20,
  parameter int POSIT_WIDTH          = 16,
  parameter int MAX_INFLIGHT         = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_rts_i,
  output logic                   s_rtr_o,
  input  logic                   s_eow_i,
  input  logic [POSIT_WIDTH-1:0] s_posit_i,
  output logic                   l_rts_o,
  input  logic                   l_rtr_i,
  output logic                   l_sow_o,
  output logic                   l_eow_o,
  output logic [POSIT_WIDTH-1:0] l_posit_o,
  input  logic                   d_rts_i,
  input  logic                   d_rtr_i,
  output logic                   d_eow_o,
  output logic                   busy_o
`ifdef POSITRON_SCHED_STATS_EN
  ,
  output logic [31:0]            stat_frames_o,
  output logic [31:0]            stat_padded_o
`endif
);

  localparam int WCW = wc_width(NB_UPSTREAM_POSITRON);
  localparam int OCW = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
  localparam int CRW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(NB_UPSTREAM_POSITRON - 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(NB_POSITRON - 1);
  localparam logic [CRW-1:0] CR_MAX  = CRW'(MAX_INFLIGHT);

  sched_state_e   state_r, state_s;
  logic [WCW-1:0] wc_r, wc_s;
  logic [OCW-1:0] oc_r;
  logic [CRW-1:0] credits_r;
  logic           admit_ok_s, pass_s, pass_xfer_s, pad_xfer_s;
  logic           frame_done_s, push_flag_s, out_xfer_s, drain_s;
  logic           head_s, empty_s, full_s;

  // Frames are admitted whole; a frame never starts without a free credit.
  assign admit_ok_s  = (credits_r < CR_MAX) & ~full_s;
  assign pass_s      = (state_r == FILL) | ((state_r == IDLE) & admit_ok_s & s_rts_i);
  assign pass_xfer_s = pass_s & s_rts_i & l_rtr_i;
  assign pad_xfer_s  = (state_r == PAD) & l_rtr_i;

  assign l_rts_o   = pass_s ? s_rts_i : (state_r == PAD);
  assign s_rtr_o   = pass_s & l_rtr_i;
  assign l_posit_o = pass_s ? s_posit_i : {POSIT_WIDTH{posit_zero_bit()}};
  assign l_sow_o   = l_rts_o & (wc_r == {WCW{1'b0}});
  assign l_eow_o   = l_rts_o & (wc_r == WC_LAST);

  // Next-state and word-count logic for the input side.
  always_comb begin
    state_s      = state_r;
    wc_s         = wc_r;
    frame_done_s = 1'b0;
    push_flag_s  = 1'b0;
    case (state_r)
      IDLE:    state_s = (admit_ok_s && s_rts_i) ? FILL : IDLE;
      FILL:    state_s = FILL;
      PAD:     state_s = PAD;
      default: state_s = IDLE;
    endcase
    if (pass_xfer_s || pad_xfer_s) begin
      if (wc_r == WC_LAST) begin
        wc_s         = {WCW{1'b0}};
        frame_done_s = 1'b1;
        push_flag_s  = pad_xfer_s | s_eow_i;
        state_s      = IDLE;
      end else if (pass_xfer_s && s_eow_i) begin
        wc_s    = wc_r + WCW'(1);
        state_s = PAD;
      end else begin
        wc_s = wc_r + WCW'(1);
      end
    end else begin
      wc_s = wc_r;
    end
  end

  // Output words seen while nothing is in flight are ignored.
  assign out_xfer_s = d_rts_i & d_rtr_i & (credits_r != {CRW{1'b0}});
  assign drain_s    = out_xfer_s & (oc_r == OC_LAST);
  assign d_eow_o    = (oc_r == OC_LAST) & head_s & d_rts_i;
  assign busy_o     = (credits_r != {CRW{1'b0}}) | (state_r != IDLE);

  // FSM, word counter, output counter and credit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wc_r      <= {WCW{1'b0}};
      oc_r      <= {OCW{1'b0}};
      credits_r <= {CRW{1'b0}};
    end else begin
      state_r <= state_s;
      wc_r    <= wc_s;
      if (out_xfer_s) begin
        oc_r <= drain_s ? {OCW{1'b0}} : oc_r + OCW'(1);
      end
      case ({frame_done_s, drain_s})
        2'b10:   credits_r <= credits_r + CRW'(1);
        2'b01:   credits_r <= credits_r - CRW'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  sched_flag_fifo #(.DEPTH(MAX_INFLIGHT)) u_flag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (frame_done_s),
    .pop   (drain_s),
    .din   (push_flag_s),
    .head  (head_s),
    .empty (empty_s),
    .full  (full_s)
  );

`ifdef POSITRON_SCHED_STATS_EN
  logic [31:0] stat_frames_r, stat_padded_r;
  assign stat_frames_o = stat_frames_r;
  assign stat_padded_o = stat_padded_r;

  // Saturating counts of completed frames and of frames that needed padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_r <= 32'd0;
      stat_padded_r <= 32'd0;
    end else begin
      if (frame_done_s && stat_frames_r != 32'hFFFF_FFFF) begin
        stat_frames_r <= stat_frames_r + 32'd1;
      end
      if (pad_xfer_s && frame_done_s && stat_padded_r != 32'hFFFF_FFFF) begin
        stat_padded_r <= stat_padded_r + 32'd1;
      end
    end
  end
`endif

`ifdef ASSERT_EN
  positron_sched_checker u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .out_xfer     (d_rts_i & d_rtr_i),
    .credits_zero (credits_r == {CRW{1'b0}})
  );
`endif

endmodule

// File: tb/tb_positron_frame_scheduler.sv
// Scoreboard bench for positron_frame_scheduler (8-word frames, 3 outputs, 2 credits).
module tb_positron_frame_scheduler;

  localparam int NU = 8;
  localparam int NP = 3;
  localparam int PW = 16;
  localparam int MI = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_rts_i = 1'b0, s_eow_i = 1'b0;
  logic [PW-1:0] s_posit_i = 16'h0000;
  logic          s_rtr_o, l_rts_o, l_sow_o, l_eow_o, d_eow_o, busy_o;
  logic [PW-1:0] l_posit_o;
  logic          l_rtr_i = 1'b1, d_rts_i = 1'b0, d_rtr_i = 1'b0;
  logic          bp_en = 1'b0;
`ifdef POSITRON_SCHED_STATS_EN
  logic [31:0]   stat_frames, stat_padded;
`endif

  logic [17:0] l_q[$];
  logic        d_q[$];
  int          tests = 0;
  int          fails = 0;

  positron_frame_scheduler #(
    .NB_UPSTREAM_POSITRON(NU), .NB_POSITRON(NP), .POSIT_WIDTH(PW), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rts_i(s_rts_i), .s_rtr_o(s_rtr_o), .s_eow_i(s_eow_i), .s_posit_i(s_posit_i),
    .l_rts_o(l_rts_o), .l_rtr_i(l_rtr_i), .l_sow_o(l_sow_o), .l_eow_o(l_eow_o),
    .l_posit_o(l_posit_o), .d_rts_i(d_rts_i), .d_rtr_i(d_rtr_i), .d_eow_o(d_eow_o),
    .busy_o(busy_o)
`ifdef POSITRON_SCHED_STATS_EN
    , .stat_frames_o(stat_frames), .stat_padded_o(stat_padded)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every layer-side and output-side transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (l_rts_o && l_rtr_i) begin
        if (l_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL l_word_unexpected: got %0h expected none", {l_sow_o, l_eow_o, l_posit_o});
        end else begin
          check("l_word", {14'd0, l_sow_o, l_eow_o, l_posit_o}, {14'd0, l_q.pop_front()});
        end
      end
      if (d_rts_i && d_rtr_i) begin
        if (d_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL d_word_unexpected: got %0b expected none", d_eow_o);
        end else begin
          check("d_eow", {31'd0, d_eow_o}, {31'd0, d_q.pop_front()});
        end
      end
    end
  end

  // Random layer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_en) l_rtr_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [PW-1:0] p, input logic e);
    bit got;
    got = 1'b0;
    s_rts_i = 1'b1; s_posit_i = p; s_eow_i = e;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_rtr_o) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL s_rtr_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    s_rts_i = 1'b0; s_eow_i = 1'b0;
  endtask

  // Sends n words; pushes expected layer words (incl. npad pads) and output tlasts.
  task automatic send_frame(input logic [PW-1:0] base, input int n, input logic tl,
                            input logic gaps, input int npad, input logic push_d);
    logic flag;
    flag = (n < NU) ? 1'b1 : tl;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      l_q.push_back({(i == 0), (i == NU - 1), base + PW'(i)});
      send_word(base + PW'(i), (i == n - 1) && flag);
    end
    for (int j = n; j < n + npad; j++) l_q.push_back({1'b0, (j == NU - 1), 16'h0000});
    if (push_d) begin
      for (int k = 0; k < NP; k++) d_q.push_back((k == NP - 1) && flag);
    end
  endtask

  task automatic wait_frame_end(input bit chk);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!l_rts_o) begin done = 1'b1; break; end
      if (chk) check("pad_s_rtr", {31'd0, s_rtr_o}, 32'd0);
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL pad_timeout: got busy expected idle");
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    d_rts_i = 1'b1; d_rtr_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    d_rts_i = 1'b0; d_rtr_i = 1'b0;
  endtask

  task automatic check_busy(input string name, input logic exp);
    @(negedge clk);
    check(name, {31'd0, busy_o}, {31'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {9'd0, s_rtr_o, l_rts_o, l_sow_o, l_eow_o, l_posit_o, d_eow_o, busy_o}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {9'd0, s_rtr_o, l_rts_o, l_sow_o, l_eow_o, l_posit_o, d_eow_o, busy_o}, 32'd0);
    @(posedge clk); #1;

    // Basic full frame with tlast on the last word.
    send_frame(16'h1000, 8, 1'b1, 1'b0, 0, 1'b1);
    wait_frame_end(1'b0);
    check_busy("busy_after_frame", 1'b1);
    drain(NP);
    check_busy("busy_after_drain", 1'b0);

    // Short DMA: tlast on word 5, three zero pads follow.
    send_frame(16'h1100, 5, 1'b1, 1'b0, 3, 1'b1);
    wait_frame_end(1'b1);
    drain(NP);

    // Credit stall: two frames in flight, outputs held off.
    d_rts_i = 1'b1;
    send_frame(16'h2000, 8, 1'b0, 1'b0, 0, 1'b1);
    wait_frame_end(1'b0);
    send_frame(16'h2100, 8, 1'b1, 1'b0, 0, 1'b1);
    wait_frame_end(1'b0);
    s_rts_i = 1'b1; s_posit_i = 16'h2200;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_s_rtr", {31'd0, s_rtr_o}, 32'd0);
      check("stall_l_rts", {31'd0, l_rts_o}, 32'd0);
    end
    @(posedge clk); #1; s_rts_i = 1'b0;
    drain(NP);
    check_busy("busy_one_credit", 1'b1);

    // Last input word of frame C lands with the last output word of frame B.
    fork
      send_frame(16'h2200, 8, 1'b0, 1'b0, 0, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1; d_rts_i = 1'b1; d_rtr_i = 1'b1;
        repeat (3) @(posedge clk);
        #1; d_rts_i = 1'b0; d_rtr_i = 1'b0;
      end
    join
    check_busy("busy_after_simul", 1'b1);
    drain(NP);
    check_busy("busy_after_simul_drain", 1'b0);

    // Backpressure across four frames with random source gaps.
    bp_en = 1'b1;
    send_frame(16'h3000, 8, 1'b1, 1'b1, 0, 1'b1); wait_frame_end(1'b1); drain(NP);
    send_frame(16'h3100, 3, 1'b1, 1'b1, 5, 1'b1); wait_frame_end(1'b1); drain(NP);
    send_frame(16'h3200, 8, 1'b0, 1'b1, 0, 1'b1); wait_frame_end(1'b1); drain(NP);
    send_frame(16'h3300, 6, 1'b1, 1'b1, 2, 1'b1); wait_frame_end(1'b1); drain(NP);
    bp_en = 1'b0;
    @(posedge clk); #1; l_rtr_i = 1'b1;
    check_busy("busy_after_bp", 1'b0);

    // Reset while the third pad word is presented.
    send_frame(16'h4000, 3, 1'b1, 1'b0, 2, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_pad", {9'd0, s_rtr_o, l_rts_o, l_sow_o, l_eow_o, l_posit_o, d_eow_o, busy_o}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    send_frame(16'h5000, 8, 1'b1, 1'b0, 0, 1'b1);
    wait_frame_end(1'b0);
    drain(NP);
    check_busy("busy_final", 1'b0);
`ifdef POSITRON_SCHED_STATS_EN
    check("stat_frames", stat_frames, 32'd1);
    check("stat_padded", stat_padded, 32'd0);
`endif
    check("l_queue_empty", l_q.size(), 32'd0);
    check("d_queue_empty", d_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/positron_frame_scheduler.md
Name: positron_frame_scheduler

Overview:
- Front-end controller for a positron layer. Cuts the upstream DMA word stream into frames of exactly NB_UPSTREAM_POSITRON posits and generates the per-frame sow/eow that the positron array consumes.
- Limits how many frames may be in flight inside the layer, and zero-pads short DMA transfers.
- Snoops the layer's output stream so it can return frame credits and attach the DMA tlast to the correct output word.

Parameters:
- NB_UPSTREAM_POSITRON, 784, words per input frame (accumulation length); must be >=2.
- NB_POSITRON, 20, output words per frame emitted by the layer; must be >=1.
- POSIT_WIDTH, 16, posit width in bits.
- MAX_INFLIGHT, 2, maximum frames admitted but not yet fully drained; allowed range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_rts_i  in  1  upstream DMA word valid
- s_rtr_o  out  1  upstream ready
- s_eow_i  in  1  upstream DMA tlast
- s_posit_i  in  POSIT_WIDTH  upstream posit
- l_rts_o  out  1  valid toward layer
- l_rtr_i  in  1  layer ready
- l_sow_o  out  1  first word of frame, qualified by l_rts_o
- l_eow_o  out  1  last word of frame, qualified by l_rts_o
- l_posit_o  out  POSIT_WIDTH  posit toward layer
- d_rts_i  in  1  layer output valid (snooped)
- d_rtr_i  in  1  downstream ready on layer output (snooped)
- d_eow_o  out  1  tlast for layer output word
- busy_o  out  1  high when any frame is in flight or a frame is partially sent

Behaviour:
- Word transfer to the layer: l_rts_o & l_rtr_i. Word transfer on the output side: d_rts_i & d_rtr_i.
- Counters:
  - wc counts 0..NB_UPSTREAM_POSITRON-1 within the current frame.
  - credits counts 0..MAX_INFLIGHT.
  - oc counts 0..NB_POSITRON-1 on the output side.
  - A tlast flag queue holds MAX_INFLIGHT entries, FIFO order, one flag per admitted frame.
- FSM states:
  - IDLE:
    - If credits < MAX_INFLIGHT and s_rts_i, go to FILL. The first word passes through in the same cycle.
    - Otherwise s_rtr_o=0 and l_rts_o=0.
  - FILL:
    - Combinational pass-through: l_rts_o=s_rts_i, s_rtr_o=l_rtr_i, l_posit_o=s_posit_i. Latency 0.
    - l_sow_o=(wc==0). l_eow_o=(wc==NB_UPSTREAM_POSITRON-1).
    - Each transfer increments wc.
    - Transfer with wc==NB_UPSTREAM_POSITRON-1: credits+1, push flag=s_eow_i, wc=0, go to IDLE.
    - Transfer with s_eow_i and wc<NB_UPSTREAM_POSITRON-1: latch pending tlast, go to PAD.
  - PAD:
    - s_rtr_o=0, l_rts_o=1, l_posit_o=0 (posit zero).
    - wc increments on each l_rtr_i.
    - Last pad word carries l_eow_o. On its transfer: credits+1, push flag=1, go to IDLE.
- IDLE also covers the "wait for credit" condition; frames are never split across a credit stall.
- Output side:
  - Each output transfer increments oc.
  - At oc==NB_POSITRON-1: oc=0, pop flag queue, credits-1.
  - d_eow_o = (oc==NB_POSITRON-1) & head flag & d_rts_i.
- Simultaneous frame admit and frame drain in one cycle: credits is unchanged; push and pop both occur.
- Credits never exceeds MAX_INFLIGHT. An output transfer arriving with credits==0 is ignored. When ASSERT_EN is defined, that case also fires an assertion.
- s_eow_i on the word with wc==NB_UPSTREAM_POSITRON-1 takes no PAD; the flag is pushed directly.
- Reset values: all counters 0, FSM=IDLE, flag queue empty. Outputs: s_rtr_o=0, l_rts_o=0, l_sow_o=0, l_eow_o=0, l_posit_o=0, d_eow_o=0, busy_o=0.
- Reset asserted mid-frame aborts the frame. The layer must share rst_n.
- busy_o = (credits!=0) | (state!=IDLE).

Optional Feature:
- Macro: POSITRON_SCHED_STATS_EN.
- With the macro defined: two extra output ports.
  - stat_frames_o (32b): frames admitted.
  - stat_padded_o (32b): frames that went through PAD.
  - Both saturate at all-ones and reset to 0.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package positron_sched_pkg holds:
  - the FSM state enum (IDLE, FILL, PAD);
  - a function computing the wc width as $clog2(NB_UPSTREAM_POSITRON);
  - the posit-zero constant helper.
- Sub-module sched_flag_fifo: MAX_INFLIGHT-deep, 1-bit FIFO with push/pop/head/empty/full, used for the tlast queue.

Test Plan:
- Basic frame: NB_UPSTREAM=8, NB_POSITRON=3, 8 words, tlast on word 8, layer mock always ready → l_sow_o on word 0, l_eow_o on word 7, no pad words, d_eow_o on the 3rd output word.
- Short DMA: tlast on word 5 of 8 → 3 zero posits follow on l_posit_o, l_eow_o on the 8th word, s_rtr_o=0 during PAD, stat_padded_o=1 if enabled.
- Credit stall: MAX_INFLIGHT=2, outputs held off with d_rtr_i=0, 3 frames offered → third frame's s_rtr_o stays 0 until 3 output words of frame 1 transfer, then admitted.
- Simultaneous events: last input word of frame 3 and last output word of frame 1 in the same cycle → credits remains 2, flag queue order preserved, d_eow_o tracks the correct frame.
- Backpressure: random l_rtr_i/s_rts_i toggling across 4 frames → word order and count exact, sow/eow exactly once per frame.
- Reset mid-PAD: rst_n low at pad word 2 → all outputs 0 next edge, busy_o=0; next frame starts with wc=0 and l_sow_o asserted.
